// File: rtl/b11_pkg.sv
// Shared definitions for the b11 round-robin scrambler scheduler.
//   XW          - width of one data word exchanged with the scrambler core
//   state_e     - scheduler FSM states
//   HOLD_DEF    - default number of cycles the core load strobe is held
//   TIMEOUT_DEF - default number of WAIT cycles before a job is aborted
package b11_pkg;

    localparam int XW          = 6;
    localparam int HOLD_DEF    = 2;
    localparam int TIMEOUT_DEF = 63;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/b11_sched_if.sv
// Bus bundle between the requesters, the scheduler and the scrambler core.
//   req/x_in            - requester levels and packed data words (requester i at [6*i+5:6*i])
//   ack/x_out/out_valid/out_err - completion pulse, result word and timeout flag
//   grant_id/busy       - current or last grant and "job in progress"
//   core_x_in/core_stbi - word and load strobe towards the core
//   core_done/core_x_out - completion pulse and result from the core
// Modport slave is the scheduler view, master is the requester/core side view.
interface b11_sched_if
    import b11_pkg::*;
#(
    parameter int NREQ = 4
) ();

    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*XW-1:0] x_in;
    logic [NREQ-1:0]    ack;
    logic [XW-1:0]      x_out;
    logic               out_valid;
    logic               out_err;
    logic [IW-1:0]      grant_id;
    logic               busy;
    logic [XW-1:0]      core_x_in;
    logic               core_stbi;
    logic               core_done;
    logic [XW-1:0]      core_x_out;

    modport slave (
        input  req, x_in, core_done, core_x_out,
        output ack, x_out, out_valid, out_err, grant_id, busy, core_x_in, core_stbi
    );

    modport master (
        output req, x_in, core_done, core_x_out,
        input  ack, x_out, out_valid, out_err, grant_id, busy, core_x_in, core_stbi
    );

endinterface

// File: rtl/b11_rr_pick.sv
// Combinational round-robin picker.
//   req    - pending request levels
//   ptr    - index of the last winner; the search starts at ptr+1
//   any    - at least one request is pending
//   winner - first set request found from ptr+1 upward, modulo NREQ
module b11_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [IW-1:0]   winner
);

    int best_s;
    int dist_s;

    // Rotated distance from ptr+1 ranks every requester; the smallest pending distance wins.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        best_s = NREQ;
        dist_s = 0;
        for (int i = 0; i < NREQ; i++) begin
            dist_s = (i + 2 * NREQ - 1 - int'(ptr)) % NREQ;
            if (req[i] && (dist_s < best_s)) begin
                any    = 1'b1;
                winner = IW'(i);
                best_s = dist_s;
            end else begin
                best_s = best_s;
            end
        end
    end

endmodule

// File: rtl/b11_sched.sv
// Round-robin scheduler sharing one scrambler core between NREQ requesters.
//   clock - single clock, all state on posedge
//   reset - asynchronous active-low reset
//   bus   - b11_sched_if slave view: requester bus (req/x_in/ack/x_out/out_valid/
//           out_err/grant_id/busy) and core side (core_x_in/core_stbi/core_done/core_x_out)
// One job: latch the winner's word, strobe the core for HOLD cycles, wait for
// core_done or TIMEOUT cycles, pulse ack/out_valid for one cycle, re-arbitrate.
module b11_sched
    import b11_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int HOLD    = HOLD_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clock,
    input  logic        reset,
    b11_sched_if.slave  bus
);

    localparam int IW = $clog2(NREQ);
    localparam int HW = $clog2(HOLD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] PTR_INIT  = IW'(NREQ - 1);

    state_e          state_r, state_next_s;
    logic [IW-1:0]   ptr_r, ptr_next_s;
    logic [IW-1:0]   grant_r, grant_next_s;
    logic [HW-1:0]   hold_r, hold_next_s;
    logic [TW-1:0]   tcnt_r, tcnt_next_s;
    logic [NREQ-1:0] ack_r, ack_next_s;
    logic [XW-1:0]   x_out_r, x_out_next_s;
    logic [XW-1:0]   core_x_r, core_x_next_s;
    logic            out_valid_r, out_valid_next_s;
    logic            out_err_r, out_err_next_s;
    logic            stbi_r, stbi_next_s;
    logic            busy_r;

    logic            any_s;
    logic [IW-1:0]   winner_s;
    logic [XW-1:0]   word_s;
    logic [NREQ-1:0] onehot_s;

    b11_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_r),
        .any    (any_s),
        .winner (winner_s)
    );

    // Winner's data slice and the one-hot ack vector for the held grant.
    always_comb begin
        word_s   = '0;
        onehot_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner_s == IW'(i)) begin
                word_s = bus.x_in[i*XW +: XW];
            end else begin
                word_s = word_s;
            end
            onehot_s[i] = (grant_r == IW'(i));
        end
    end

    // Next-state and next-output logic; pulses default low, data holds.
    always_comb begin
        state_next_s     = state_r;
        ptr_next_s       = ptr_r;
        grant_next_s     = grant_r;
        hold_next_s      = hold_r;
        tcnt_next_s      = tcnt_r;
        ack_next_s       = '0;
        x_out_next_s     = x_out_r;
        core_x_next_s    = core_x_r;
        out_valid_next_s = 1'b0;
        out_err_next_s   = 1'b0;
        stbi_next_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    core_x_next_s = word_s;
                    grant_next_s  = winner_s;
                    ptr_next_s    = winner_s;
                    hold_next_s   = HOLD_INIT;
                    stbi_next_s   = 1'b1;
                    state_next_s  = LOAD;
                end else begin
                    state_next_s  = IDLE;
                end
            end
            LOAD: begin
                if (hold_r == '0) begin
                    tcnt_next_s  = '0;
                    state_next_s = WAIT;
                end else begin
                    hold_next_s  = hold_r - HW'(1);
                    stbi_next_s  = 1'b1;
                end
            end
            WAIT: begin
                // core_done takes precedence over an expiring timeout.
                if (bus.core_done) begin
                    x_out_next_s     = bus.core_x_out;
                    ack_next_s       = onehot_s;
                    out_valid_next_s = 1'b1;
                    state_next_s     = DONE;
                end else if (tcnt_r == TO_LAST) begin
                    x_out_next_s     = '0;
                    ack_next_s       = onehot_s;
                    out_valid_next_s = 1'b1;
                    out_err_next_s   = 1'b1;
                    state_next_s     = DONE;
                end else begin
                    tcnt_next_s      = tcnt_r + TW'(1);
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, counters and all output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            ptr_r       <= PTR_INIT;
            grant_r     <= '0;
            hold_r      <= '0;
            tcnt_r      <= '0;
            ack_r       <= '0;
            x_out_r     <= '0;
            core_x_r    <= '0;
            out_valid_r <= 1'b0;
            out_err_r   <= 1'b0;
            stbi_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            ptr_r       <= ptr_next_s;
            grant_r     <= grant_next_s;
            hold_r      <= hold_next_s;
            tcnt_r      <= tcnt_next_s;
            ack_r       <= ack_next_s;
            x_out_r     <= x_out_next_s;
            core_x_r    <= core_x_next_s;
            out_valid_r <= out_valid_next_s;
            out_err_r   <= out_err_next_s;
            stbi_r      <= stbi_next_s;
            busy_r      <= (state_next_s != IDLE);
        end
    end

    assign bus.ack       = ack_r;
    assign bus.x_out     = x_out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_err   = out_err_r;
    assign bus.grant_id  = grant_r;
    assign bus.busy      = busy_r;
    assign bus.core_x_in = core_x_r;
    assign bus.core_stbi = stbi_r;

endmodule

// File: tb/tb_b11_sched.sv
// Self-checking bench for b11_sched: the bench plays both the requesters and
// the scrambler core, and predicts grants, latencies and results from a
// round-robin pointer and the job rules.
module tb_b11_sched;
    import b11_pkg::*;

    localparam int NREQ    = 4;
    localparam int HOLD    = HOLD_DEF;
    localparam int TIMEOUT = TIMEOUT_DEF;
    localparam int XINW    = NREQ * XW;

    logic clock;
    logic reset;

    b11_sched_if #(.NREQ(NREQ)) bus ();

    b11_sched #(
        .NREQ    (NREQ),
        .HOLD    (HOLD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int            n_pass  = 0;
    int            n_fail  = 0;
    int            n_total = 0;
    int            ptr_m;
    logic [XW-1:0] x_out_m;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first pending requester after the last winner, modulo NREQ.
    function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
        int rv = 32'(r);
        int cand;
        for (int step = 1; step <= NREQ; step++) begin
            cand = (p + step) % NREQ;
            if (((rv >> cand) & 1) == 1) return cand;
        end
        return -1;
    endfunction

    // One complete job; called at a negedge with the DUT idle and req non-zero.
    // k = WAIT cycle on which the core answers (0 = never), res = core result.
    task automatic run_job(input int k, input logic [XW-1:0] res, input bit drop_req,
                           input bit scramble, output int w);
        logic [XW-1:0] word;
        int            cnt;
        int            waited;
        int            exp_wait;
        bit            exp_err;
        w    = model_pick(bus.req, ptr_m);
        word = XW'(bus.x_in >> (w * XW));
        @(negedge clock);
        check("stbi_after_grant", 32'(bus.core_stbi), 32'(1));
        check("grant_id", 32'(bus.grant_id), 32'(w));
        check("core_x_in", 32'(bus.core_x_in), 32'(word));
        check("busy_in_job", 32'(bus.busy), 32'(1));
        if (drop_req) bus.req = bus.req & ~(NREQ'(1) << w);
        if (scramble) bus.x_in = XINW'($urandom);
        cnt = 1;
        for (int i = 0; i < HOLD + 4; i++) begin
            @(negedge clock);
            if (bus.core_stbi !== 1'b1) break;
            cnt++;
        end
        check("stbi_hold_cycles", 32'(cnt), 32'(HOLD));
        check("core_x_in_stable", 32'(bus.core_x_in), 32'(word));
        waited = 0;
        for (int i = 1; i <= TIMEOUT + 8; i++) begin
            bus.core_done  = (i == k);
            bus.core_x_out = (i == k) ? res : XW'($urandom);
            @(negedge clock);
            if (bus.out_valid === 1'b1) begin
                waited = i;
                break;
            end
        end
        bus.core_done = 1'b0;
        exp_err  = !(k >= 1 && k <= TIMEOUT);
        exp_wait = exp_err ? TIMEOUT : k;
        x_out_m  = exp_err ? '0 : res;
        check("wait_cycles", 32'(waited), 32'(exp_wait));
        check("ack_onehot", 32'(bus.ack), 32'(1) << w);
        check("x_out", 32'(bus.x_out), 32'(x_out_m));
        check("out_err", 32'(bus.out_err), 32'(exp_err));
        @(negedge clock);
        check("out_valid_pulse", 32'(bus.out_valid), 32'(0));
        check("ack_pulse", 32'(bus.ack), 32'(0));
        check("busy_idle", 32'(bus.busy), 32'(0));
        check("x_out_held", 32'(bus.x_out), 32'(x_out_m));
        ptr_m = w;
    endtask

    initial begin
        int w;
        int fair_exp[5] = '{0, 1, 2, 3, 0};
        int vcount;

        reset          = 1'b0;
        bus.req        = '0;
        bus.x_in       = '0;
        bus.core_done  = 1'b0;
        bus.core_x_out = '0;
        ptr_m          = NREQ - 1;
        x_out_m        = '0;

        // Reset values
        repeat (2) @(negedge clock);
        check("rst_ack", 32'(bus.ack), 32'(0));
        check("rst_x_out", 32'(bus.x_out), 32'(0));
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_out_err", 32'(bus.out_err), 32'(0));
        check("rst_grant_id", 32'(bus.grant_id), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_core_x_in", 32'(bus.core_x_in), 32'(0));
        check("rst_core_stbi", 32'(bus.core_stbi), 32'(0));
        reset = 1'b1;
        @(negedge clock);
        check("idle_no_req_stbi", 32'(bus.core_stbi), 32'(0));

        // Fairness: all four requesting continuously, core answers on WAIT cycle 1
        bus.req  = 4'b1111;
        bus.x_in = XINW'($urandom);
        for (int j = 0; j < 5; j++) begin
            run_job(1, XW'($urandom), 1'b0, 1'b0, w);
            check("fair_order", 32'(bus.grant_id), 32'(fair_exp[j]));
        end

        // Single job: requester 0 with word 13, core result 42
        bus.req             = 4'b0001;
        bus.x_in            = XINW'($urandom);
        bus.x_in[XW-1:0]    = 6'd13;
        run_job(4, 6'd42, 1'b0, 1'b0, w);
        bus.req = '0;

        // Timeout: core never answers
        bus.req = 4'b0100;
        run_job(0, 6'd0, 1'b0, 1'b0, w);
        bus.req = '0;

        // core_done on the last WAIT cycle wins over the timeout
        bus.req = 4'b0100;
        run_job(TIMEOUT, 6'd7, 1'b0, 1'b0, w);
        bus.req = '0;

        // Spurious core_done while idle
        bus.core_done  = 1'b1;
        bus.core_x_out = ~x_out_m;
        @(negedge clock);
        bus.core_done  = 1'b0;
        check("spurious_busy", 32'(bus.busy), 32'(0));
        check("spurious_valid", 32'(bus.out_valid), 32'(0));
        check("spurious_x_out", 32'(bus.x_out), 32'(x_out_m));
        check("spurious_stbi", 32'(bus.core_stbi), 32'(0));

        // Request withdrawn before it is sampled: no grant
        bus.req = 4'b1000;
        #2;
        bus.req = '0;
        @(negedge clock);
        check("dropped_req_stbi", 32'(bus.core_stbi), 32'(0));
        check("dropped_req_busy", 32'(bus.busy), 32'(0));

        // Requester 1 drops req during LOAD and x_in changes after grant
        bus.req  = 4'b0010;
        bus.x_in = XINW'($urandom);
        run_job(3, XW'($urandom), 1'b1, 1'b1, w);
        bus.req = '0;

        // Randomized jobs against the reference model
        for (int j = 0; j < 24; j++) begin
            int kk;
            bus.req  = NREQ'($urandom_range(1, 15));
            bus.x_in = XINW'($urandom);
            kk = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
            run_job(kk, XW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
        end
        bus.req = '0;

        // Reset in the middle of WAIT
        bus.req  = 4'b0110;
        bus.x_in = XINW'($urandom);
        repeat (HOLD + 4) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_ack", 32'(bus.ack), 32'(0));
        check("midrst_x_out", 32'(bus.x_out), 32'(0));
        check("midrst_valid", 32'(bus.out_valid), 32'(0));
        check("midrst_err", 32'(bus.out_err), 32'(0));
        check("midrst_grant", 32'(bus.grant_id), 32'(0));
        check("midrst_busy", 32'(bus.busy), 32'(0));
        check("midrst_core_x", 32'(bus.core_x_in), 32'(0));
        check("midrst_stbi", 32'(bus.core_stbi), 32'(0));
        bus.req = '0;
        @(negedge clock);
        reset   = 1'b1;
        ptr_m   = NREQ - 1;
        x_out_m = '0;
        vcount  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (bus.out_valid !== 1'b0 || bus.ack !== '0) vcount++;
        end
        check("midrst_no_ack", 32'(vcount), 32'(0));
        bus.req  = 4'b1011;
        bus.x_in = XINW'($urandom);
        run_job(2, XW'($urandom), 1'b0, 1'b0, w);
        check("post_rst_grant0", 32'(bus.grant_id), 32'(0));
        bus.req = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/b11_sched.md
Name: b11_sched

Overview:
- Round-robin scheduler sharing one 6-bit scrambler core (x_in/stbi/x_out datapath with a completion strobe) between NREQ requesters.
- Picks one pending requester and presents its 6-bit word to the core with a stbi load window.
- Waits for core completion or a timeout, returns the 6-bit result to that requester, then re-arbitrates.
- Sits between the requester bus and the single core instance.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- HOLD, 2: cycles core_stbi is held high per job, >=1.
- TIMEOUT, 63: maximum WAIT cycles before abort, >=1.

Ports:
- clock  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  level request per requester; held until its ack.
- x_in  in  NREQ*6  packed data; requester i at [6*i+5:6*i].
- ack  out  NREQ  one-cycle pulse to the served requester.
- x_out  out  6  result word; valid when out_valid is high, held otherwise.
- out_valid  out  1  one-cycle pulse, coincident with ack.
- out_err  out  1  one-cycle pulse with out_valid when the job timed out.
- grant_id  out  $clog2(NREQ)  index of current or last granted requester.
- busy  out  1  high in every state except IDLE.
- core_x_in  out  6  data to core.
- core_stbi  out  1  load strobe to core.
- core_done  in  1  core completion pulse; core_x_out is valid in the same cycle.
- core_x_out  in  6  core result.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - ack, x_out, out_valid, out_err, core_x_in, core_stbi, busy all 0.
  - grant_id=0.
  - Priority pointer=NREQ-1, so requester 0 wins first.
- All outputs are registered.
- FSM states: IDLE, LOAD, WAIT, DONE.
- IDLE:
  - If any req bit is set, pick the first set bit searching from pointer+1 upward, modulo NREQ.
  - On that edge: latch x_in slice into core_x_in, set grant_id, pointer<=winner, core_stbi<=1, load hold counter with HOLD-1, go to LOAD.
  - No req: stay in IDLE, core_stbi=0.
- LOAD:
  - core_stbi=1 for exactly HOLD cycles.
  - When the hold counter reaches 0: core_stbi<=0, timeout counter<=0, go to WAIT.
- WAIT:
  - core_stbi=0; core_x_in stays stable.
  - Timeout counter increments every cycle.
  - If core_done=1: capture core_x_out into x_out, err<=0, go to DONE.
  - Else if counter==TIMEOUT-1: x_out<=0, err<=1, go to DONE.
  - core_done and timeout expiry in the same cycle: core_done wins, no error.
- DONE (one cycle):
  - ack[grant_id]=1, out_valid=1, out_err=err.
  - Next edge: IDLE.
  - A request sampled in the same IDLE cycle that follows is eligible immediately.
- Latency:
  - req seen in IDLE at edge t: core_stbi high for edges t+1..t+HOLD.
  - out_valid asserted 1 cycle after core_done is sampled.
  - Minimum turnaround for one job = HOLD + 3 cycles.
- core_done outside WAIT is ignored and does not affect state.
- req dropped after grant: the job still completes and ack is still pulsed.
- req dropped before sampling: no grant.
- req[grant_id] still high in IDLE after its ack: treated as a new request; the pointer gives other requesters priority.
- x_in changes after grant have no effect; the word is latched at grant.
- Reset mid-job: all state returns to reset values immediately; no ack and no out_valid for the aborted job.
- Counter widths:
  - Hold counter: $clog2(HOLD+1).
  - Timeout counter: $clog2(TIMEOUT+1).
  - No wrap-around is possible within a job.

Decomposition:
- Package b11_pkg:
  - XW=6.
  - State enum {IDLE, LOAD, WAIT, DONE}.
  - Default constants HOLD_DEF=2, TIMEOUT_DEF=63.
- One sub-module, b11_rr_pick:
  - Combinational round-robin picker.
  - Inputs: req[NREQ], pointer. Outputs: any, winner index.
- The FSM, counters and output registers live in b11_sched.

Test Plan:
- Single job:
  - Stimulus: req=0001, x_in[0]=6'd13, core returns done with 6'd42 four cycles after stbi falls.
  - Response: core_stbi high exactly 2 cycles with core_x_in=13; x_out=42; ack=0001 and out_valid for one cycle; out_err=0.
- Fairness:
  - Stimulus: req=1111 held continuously, core done after 1 WAIT cycle.
  - Response: grant order 0,1,2,3,0; each ack pulses once per round.
- Timeout:
  - Stimulus: req=0100, core_done never asserted.
  - Response: after 63 WAIT cycles, ack=0100, x_out=0, out_err=1.
- Simultaneous events:
  - Stimulus: core_done=1 on WAIT cycle 63 with core_x_out=6'd7.
  - Response: x_out=7, out_err=0.
- Reset mid-WAIT:
  - Stimulus: reset low for 1 cycle during WAIT.
  - Response: all outputs 0 immediately; no ack; the next grant goes to requester 0 if it is requesting.
- Spurious done and late req:
  - Stimulus: core_done pulse in IDLE; req[1] dropped during LOAD.
  - Response: spurious done has no effect; requester 1 is still acked with its result.
